// File: rtl/serial_calc_pkg.sv
// Shared encodings and sizing helpers for the bit-serial three-operand calculator.
package serial_calc_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_NEG_A = 2'b01;
   localparam logic [1:0] OP_NEG_B = 2'b10;
   localparam logic [1:0] OP_NEG_C = 2'b11;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam int unsigned DEF_WIDTH = 8;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_calc_slice.sv
// One-bit slice of a three-operand adder; the 2-bit carry covers sums up to 5.
module serial_calc_slice (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       c_i,
   input  logic [1:0] carry,
   output logic       r_i,
   output logic [1:0] carry_next
);

   logic [2:0] t;

   always_comb begin
      t          = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i} + {1'b0, carry};
      r_i        = t[0];
      carry_next = t[2:1];
   end

endmodule

// File: rtl/serial_calc.sv
// Bit-serial A/B/C add-with-one-negated calculator: one result bit per clock,
// valid/ready on both the request and the response side.
module serial_calc
   import serial_calc_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             c_out
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
   logic [1:0]       carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             r_bit;
   logic [1:0]       carry_next;

   serial_calc_slice u_slice (
      .a_i        (a_q[0]),
      .b_i        (b_q[0]),
      .c_i        (c_q[0]),
      .carry      (carry_q),
      .r_i        (r_bit),
      .carry_next (carry_next)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Two's complement negation: invert here, the +1 rides in as initial carry.
               a_d     = (op == OP_NEG_A) ? ~a : a;
               b_d     = (op == OP_NEG_B) ? ~b : b;
               c_d     = (op == OP_NEG_C) ? ~c : c;
               carry_d = {1'b0, op != OP_ADD};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            c_d     = c_q >> 1;
            res_d   = {r_bit, res_q[WIDTH-1:1]};
            carry_d = carry_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         carry_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign res       = res_q;
   // After the last bit the carry register holds S[WIDTH+1:WIDTH].
   assign c_out     = |carry_q;

endmodule

// File: tb/tb_serial_calc.sv
// Directed bench for serial_calc with hand-computed results.
module tb_serial_calc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b, c;
   logic [1:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] res;
   logic       c_out;

   int n_chk = 0;
   int n_bad = 0;

   serial_calc #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .c_out     (c_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic start_req(input logic [1:0] o, input logic [7:0] av, bv, cv);
      @(negedge clk);
      in_valid = 1'b1;
      op = o; a = av; b = bv; c = cv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs: the captured request must not depend on them anymore.
      op = ~o; a = ~av; b = bv + 8'd77; c = cv ^ 8'h5a;
   endtask

   // Counts edges after the accept edge until out_valid is seen, bounded.
   task automatic wait_out(input string tag);
      int  lat;
      bit  busy_ok;
      lat     = 0;
      busy_ok = 1'b1;
      while (!out_valid && lat < 20) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, 8);
      chk({tag, "_busy"}, busy_ok, 1);
      chk({tag, "_ir_done"}, in_ready, 0);
   endtask

   task automatic release_rsp(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_ov_drop"}, out_valid, 0);
      chk({tag, "_ir_rise"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [7:0] av, bv, cv,
                      input logic [7:0] er, input logic ec);
      start_req(o, av, bv, cv);
      wait_out(tag);
      chk({tag, "_res"}, res, er);
      chk({tag, "_cout"}, c_out, ec);
      release_rsp(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c = '0; op = '0;
      #23;
      chk("rst_ir", in_ready, 1);
      chk("rst_ov", out_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_cout", c_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run("add_small", 2'b00, 8'd10, 8'd20, 8'd30, 8'd60, 1'b0);
      run("add_ovf", 2'b00, 8'd200, 8'd100, 8'd50, 8'd94, 1'b1);
      run("neg_b", 2'b10, 8'd0, 8'd1, 8'd0, 8'd255, 1'b0);

      // Result hold while the sink stalls, with noise on the request side.
      start_req(2'b11, 8'd100, 8'd50, 8'd30);
      wait_out("hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a = a + 8'd13; b = b ^ 8'hff; c = c + 8'd1; op = op + 2'd1;
         @(posedge clk);
         #1;
         chk("hold_res", res, 120);
         chk("hold_ov", out_valid, 1);
      end
      chk("hold_cout", c_out, 1);
      @(negedge clk);
      in_valid = 1'b0;
      release_rsp("hold");
      @(posedge clk);
      #1;
      chk("hold_no_capture", in_ready, 1);

      // out_ready already high before out_valid rises.
      @(negedge clk);
      out_ready = 1'b1;
      start_req(2'b00, 8'd1, 8'd1, 8'd1);
      wait_out("early");
      chk("early_res", res, 3);
      @(posedge clk);
      #1;
      chk("early_ov_drop", out_valid, 0);
      out_ready = 1'b0;

      // Back-to-back: next request waiting while the first response is released.
      start_req(2'b00, 8'd1, 8'd2, 8'd3);
      wait_out("b2b1");
      chk("b2b1_res", res, 6);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = 2'b01; a = 8'd5; b = 8'd10; c = 8'd20;
      @(posedge clk);
      #1;
      chk("b2b_ov_drop", out_valid, 0);
      chk("b2b_ir_rise", in_ready, 1);
      @(posedge clk);
      #1;
      chk("b2b_accept", in_ready, 0);
      in_valid = 1'b0; out_ready = 1'b0;
      a = 8'd0; b = 8'd0; c = 8'd0;
      wait_out("b2b2");
      chk("b2b2_res", res, 25);
      chk("b2b2_cout", c_out, 1);
      release_rsp("b2b2");

      // Asynchronous reset in the middle of a computation.
      start_req(2'b00, 8'd255, 8'd255, 8'd255);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_ir", in_ready, 1);
      chk("mid_rst_res", res, 0);
      chk("mid_rst_cout", c_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_rst_no_ov", out_valid, 0);
      run("post_rst", 2'b01, 8'd30, 8'd10, 8'd5, 8'd241, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
